sw_debounce: RTL and testbench

SW_DEBOUNCE -- requirements
Module: sw_debounce

---
 rtl/sw_debounce.sv | 78 +++++++
 tb/tb_sw_debounce.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - eight-bit switch debouncer with registered edge pulses
//
// Ports:
//   clk       in   system clock, all state on the rising edge
//   rst       in   synchronous active-high reset
//   sw_raw    in   [7:0] asynchronous, bouncing switch levels
//   sw_db     out  [7:0] debounced, clk-synchronous switch levels
//   sw_rise   out  [7:0] one-cycle pulse per bit, sw_db went 0->1
//   sw_fall   out  [7:0] one-cycle pulse per bit, sw_db went 1->0
//   sw_change out  one-cycle pulse, OR of all rise/fall bits
module sw_debounce #(
  parameter int unsigned STABLE_CYCLES = 1000000,
  parameter int unsigned CNT_W         = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sw_raw,
  output logic [7:0] sw_db,
  output logic [7:0] sw_rise,
  output logic [7:0] sw_fall,
  output logic       sw_change
);

  // Elaboration-time guard on the parameter range and counter width.
  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 32'h00FF_FFFF ||
      (64'(1) << CNT_W) <= 64'(STABLE_CYCLES)) begin : g_param_check
    $error("sw_debounce: illegal STABLE_CYCLES/CNT_W combination");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [7:0]       sync1;
  logic [7:0]       sync2;
  logic [CNT_W-1:0] cnt [8];
  logic [7:0]       differ;
  logic [7:0]       accept;

  // A bit is accepted on the edge where it has already differed for
  // STABLE_CYCLES-1 edges and still differs.
  always_comb begin
    differ = sync2 ^ sw_db;
    accept = '0;
    for (int i = 0; i < 8; i++) begin
      accept[i] = differ[i] && (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      sw_db     <= '0;
      sw_rise   <= '0;
      sw_fall   <= '0;
      sw_change <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
      // Any agreement (glitch back) or an acceptance restarts the interval,
      // so the counter never passes CNT_LAST and never wraps.
      for (int i = 0; i < 8; i++) begin
        if (!differ[i] || accept[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
      sw_db     <= sw_db ^ accept;
      sw_rise   <= accept & sync2;
      sw_fall   <= accept & ~sync2;
      sw_change <= |accept;
    end
  end

endmodule

// File: tb/tb_sw_debounce.sv
// tb/tb_sw_debounce.sv - scoreboard bench for sw_debounce with a windowed reference model
module tb_sw_debounce;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sw_raw = 8'h00;
  logic [7:0] sw_db;
  logic [7:0] sw_rise;
  logic [7:0] sw_fall;
  logic       sw_change;

  sw_debounce #(.STABLE_CYCLES(S), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_raw    (sw_raw),
    .sw_db     (sw_db),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .sw_change (sw_change)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] db;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       change;
  } obs_t;

  obs_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         chg_pulses = 0;

  // Reference model: raw samples since reset, and the synchronized view of
  // the last S edges. A bit is accepted when all of its last S synchronized
  // samples disagree with the debounced value.
  logic [7:0] m_raw[$];
  logic [7:0] m_x[$];
  logic [7:0] m_db = 8'h00;

  task automatic step(input logic [7:0] raw, input logic r);
    obs_t       e;
    logic [7:0] x;
    logic [7:0] acc;
    @(negedge clk);
    sw_raw = raw;
    rst    = r;
    e      = '0;
    if (r) begin
      m_raw.delete();
      m_x.delete();
      m_db = 8'h00;
    end else begin
      // value seen on this edge is the raw sample from two edges earlier
      x = (m_raw.size() >= 2) ? m_raw[m_raw.size()-2] : 8'h00;
      m_raw.push_back(raw);
      if (m_raw.size() > 2) void'(m_raw.pop_front());
      m_x.push_back(x);
      if (m_x.size() > S) void'(m_x.pop_front());
      acc = 8'h00;
      if (m_x.size() == S) begin
        acc = 8'hFF;
        foreach (m_x[k]) acc &= (m_x[k] ^ m_db);
      end
      e.rise   = acc & ~m_db;
      e.fall   = acc & m_db;
      e.change = |acc;
      m_db     = m_db ^ acc;
      e.db     = m_db;
    end
    exp_q.push_back(e);
  endtask

  task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  // Monitor: one observation per clock edge, compared against the queue head.
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {sw_db, sw_rise, sw_fall, sw_change};
        if (sw_change === 1'b1) chg_pulses++;
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL scoreboard t=%0t got db=%h rise=%h fall=%h chg=%b want db=%h rise=%h fall=%h chg=%b",
                   $time, a.db, a.rise, a.fall, a.change, e.db, e.rise, e.fall, e.change);
        end
      end
    end
  end

  task automatic settle_check(input string name, input logic [7:0] want_db, input int want_pulses);
    @(posedge clk);
    #2;
    check_val({name, "_db"}, sw_db, want_db);
    check_val({name, "_pulses"}, 8'(chg_pulses), 8'(want_pulses));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    logic [7:0] mask;
    int         waited;

    repeat (3) step(8'h00, 1'b1);
    repeat (20) step(8'h00, 1'b0);
    settle_check("idle", 8'h00, 0);

    repeat (10) step(8'h01, 1'b0);
    settle_check("rise0", 8'h01, 1);

    for (int k = 0; k < 20; k++) step((k % 2) ? 8'h09 : 8'h01, 1'b0);
    repeat (10) step(8'h01, 1'b0);
    settle_check("glitch3", 8'h01, 1);

    repeat (10) step(8'hFF, 1'b0);
    settle_check("allhigh", 8'hFF, 2);
    repeat (10) step(8'h5A, 1'b0);
    settle_check("fall_a5", 8'h5A, 3);

    repeat (3) step(8'hDA, 1'b0);
    step(8'hDA, 1'b1);
    repeat (10) step(8'hDA, 1'b0);
    settle_check("rst_mid", 8'hDA, 4);

    repeat (10) step(8'h00, 1'b0);
    settle_check("clear", 8'h00, 5);
    repeat (3) step(8'h01, 1'b0);
    repeat (10) step(8'h00, 1'b0);
    settle_check("short3", 8'h00, 5);
    repeat (4) step(8'h01, 1'b0);
    repeat (10) step(8'h00, 1'b0);
    settle_check("exact4", 8'h00, 7);

    r = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      mask = 8'h00;
      for (int b = 0; b < 8; b++) mask[b] = ($urandom_range(0, 7) == 0);
      r = r ^ mask;
      step(r, ($urandom_range(0, 299) == 0));
    end
    repeat (10) step(r, 1'b0);

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      #2;
      waited++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
